// File: rtl/wr_unit_packer_pkg.sv
// Shared definitions for the frame-buffer unit packer and its read-side unpacker.
package wr_unit_packer_pkg;

    localparam int P_MAX_UNIT_NUM     = 32;
    localparam int P_BIT_NUM_PER_UNIT = 8;
    localparam int W                  = P_MAX_UNIT_NUM * P_BIT_NUM_PER_UNIT;
    localparam int PW                 = $clog2(P_MAX_UNIT_NUM);

    // Legal units-per-beat table: power-of-two divisors of the word, anything else is 0.
    function automatic int decode_units(input int u, input int max_units);
        if ((u == 2 || u == 4 || u == 8 || u == 16) && (u < max_units))
            return u;
        return 0;
    endfunction

endpackage

// File: rtl/wr_unit_packer_unit_lane_shift.sv
// Keeps the low i_units units of a beat and moves them up to unit slot i_ptr.
module unit_lane_shift #(
    parameter int C_MAX_UNIT_NUM     = 32,
    parameter int C_BIT_NUM_PER_UNIT = 8
) (
    input  logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] i_data,
    input  logic [$clog2(C_MAX_UNIT_NUM)-1:0]            i_units,
    input  logic [$clog2(C_MAX_UNIT_NUM)-1:0]            i_ptr,
    output logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] o_data
);

    localparam int B = C_BIT_NUM_PER_UNIT;

    logic [C_MAX_UNIT_NUM*B-1:0] w_masked;

    // Units at or above the beat's unit count carry no data and are zeroed.
    for (genvar g = 0; g < C_MAX_UNIT_NUM; g++) begin : g_mask
        assign w_masked[g*B +: B] = (g < int'(i_units)) ? i_data[g*B +: B] : '0;
    end

    assign o_data = w_masked << (int'(i_ptr) * B);

endmodule

// File: rtl/wr_unit_packer.sv
// Packs variable-size input beats LSB-first into full words for the frame-buffer write FIFO.
module wr_unit_packer
    import wr_unit_packer_pkg::*;
#(
    parameter int C_MAX_UNIT_NUM     = P_MAX_UNIT_NUM,
    parameter int C_BIT_NUM_PER_UNIT = P_BIT_NUM_PER_UNIT
) (
    input  logic                                         CLK_I,
    input  logic                                         RST_I,
    input  logic                                         VS_I,
    input  logic                                         DE_I,
    input  logic [$clog2(C_MAX_UNIT_NUM)-1:0]            UNITS_I,
    input  logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] DATA_I,
    input  logic                                         FULL_I,
    output logic                                         WR_O,
    output logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] DATA_O,
    output logic                                         OVF_O
);

    localparam int UW = $clog2(C_MAX_UNIT_NUM);
    localparam int DW = C_MAX_UNIT_NUM * C_BIT_NUM_PER_UNIT;

    logic [UW-1:0] r_units;
    logic [UW-1:0] r_ptr;
    logic          r_vs_d;
    logic          r_s1_vld;
    logic          r_s1_wrap;
    logic          r_s1_flush;
    logic [DW-1:0] r_s1_data;
    logic [UW-1:0] r_s1_ptr;
    logic [UW-1:0] r_s1_units;
    logic [DW-1:0] r_accum;
    logic          r_wr;
    logic [DW-1:0] r_data;
    logic          r_ovf;

    logic          w_acc;
    logic          w_vs_rise;
    logic [UW-1:0] w_ptr_nxt;
    logic [DW-1:0] w_shifted;

    assign w_acc     = DE_I & ~VS_I & (r_units != '0);
    assign w_vs_rise = VS_I & ~r_vs_d;
    assign w_ptr_nxt = r_ptr + r_units;

    // Beat size is only sampled at reset or during VS so it stays constant within a frame.
    always_ff @(posedge CLK_I) begin
        if (RST_I | VS_I)
            r_units <= UW'(decode_units(int'(UNITS_I), C_MAX_UNIT_NUM));
    end

    // Stage 1: capture the accepted beat with its slot position; advance the fill pointer.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_vs_d     <= 1'b0;
            r_ptr      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_wrap  <= 1'b0;
            r_s1_flush <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ptr   <= '0;
            r_s1_units <= '0;
        end else begin
            r_vs_d     <= VS_I;
            r_s1_vld   <= w_acc;
            // A wrapping sum means this beat fills the last slot of the word.
            r_s1_wrap  <= w_acc & (w_ptr_nxt <= r_ptr);
            // Flush trails the last beat by one stage so that beat is merged first.
            r_s1_flush <= w_vs_rise & (r_ptr != '0);
            r_s1_data  <= DATA_I;
            r_s1_ptr   <= r_ptr;
            r_s1_units <= r_units;
            if (w_vs_rise)
                r_ptr <= '0;
            else if (w_acc)
                r_ptr <= w_ptr_nxt;
        end
    end

    unit_lane_shift #(
        .C_MAX_UNIT_NUM    (C_MAX_UNIT_NUM),
        .C_BIT_NUM_PER_UNIT(C_BIT_NUM_PER_UNIT)
    ) u_shift (
        .i_data (r_s1_data),
        .i_units(r_s1_units),
        .i_ptr  (r_s1_ptr),
        .o_data (w_shifted)
    );

    // Stage 2: merge into the accumulator, emit on word completion or frame flush.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_accum <= '0;
            r_wr    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_wr <= (r_s1_vld & r_s1_wrap) | r_s1_flush;
            if (r_s1_flush) begin
                r_data  <= r_accum;
                r_accum <= '0;
            end else if (r_s1_vld) begin
                if (r_s1_wrap) begin
                    r_data  <= r_accum | w_shifted;
                    r_accum <= '0;
                end else begin
                    r_accum <= r_accum | w_shifted;
                end
            end
        end
    end

    // Sticky overflow: a write went out while the FIFO reported full.
    always_ff @(posedge CLK_I) begin
        if (RST_I)
            r_ovf <= 1'b0;
        else if (r_wr & FULL_I)
            r_ovf <= 1'b1;
    end

    assign WR_O   = r_wr;
    assign DATA_O = r_data;
    assign OVF_O  = r_ovf;

endmodule

// File: tb/tb_wr_unit_packer.sv
// Directed bench for wr_unit_packer: scenario table plus reset/overflow sequences.
module tb_wr_unit_packer;

    localparam int N  = 32;
    localparam int B  = 8;
    localparam int LW = N * B;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst, vs, de, full;
    logic [PW-1:0] units;
    logic [LW-1:0] din;
    logic          wr;
    logic [LW-1:0] dout;
    logic          ovf;

    always #5 clk = ~clk;

    wr_unit_packer dut (
        .CLK_I  (clk),
        .RST_I  (rst),
        .VS_I   (vs),
        .DE_I   (de),
        .UNITS_I(units),
        .DATA_I (din),
        .FULL_I (full),
        .WR_O   (wr),
        .DATA_O (dout),
        .OVF_O  (ovf)
    );

    typedef struct {
        logic [LW-1:0] w;
        int            c;
    } wr_t;

    typedef struct {
        logic [PW-1:0] u;
        int            nb;
        int            mul;
        int            umul;
        int            seed;
        bit            fl;
        int            nexp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [7:0]  mq[$];
    vec_t        tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        wr_t t;
        if (wr === 1'b1) begin
            t.w = dout;
            t.c = cyc;
            obs_q.push_back(t);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_beat(int k, int mul, int umul, int seed, int nu);
        logic [LW-1:0] d;
        for (int u = 0; u < N; u++)
            d[u*B +: B] = (u < nu) ? 8'(k*mul + u*umul + seed) : (8'hA5 ^ 8'(u));
        return d;
    endfunction

    task automatic pop_word(int c);
        wr_t t;
        t.w = '0;
        for (int j = 0; j < N; j++)
            if (mq.size() > 0) t.w[j*B +: B] = mq.pop_front();
        t.c = c;
        exp_q.push_back(t);
    endtask

    task automatic beat(logic [LW-1:0] d, int nu);
        de  = 1'b1;
        din = d;
        for (int u = 0; u < nu; u++) begin
            mq.push_back(d[u*B +: B]);
            if (mq.size() == N) pop_word(cyc + 2);
        end
        tick();
        de = 1'b0;
    endtask

    task automatic vs_pulse(logic [PW-1:0] u);
        vs    = 1'b1;
        units = u;
        if (mq.size() > 0) pop_word(cyc + 2);
        tick();
        vs = 1'b0;
    endtask

    task automatic compare(string tag, int nexp);
        int n;
        repeat (4) tick();
        chk($sformatf("%s write count", tag), LW'(obs_q.size()), LW'(nexp));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s word%0d data", tag, i), obs_q[i].w, exp_q[i].w);
            chk($sformatf("%s word%0d cycle", tag, i), LW'(obs_q[i].c), LW'(exp_q[i].c));
        end
    endtask

    initial begin
        logic [LW-1:0] w0;
        int            nu;

        tbl[0] = '{u: 5'd4,  nb: 16, mul: 1,  umul: 0, seed: 0,    fl: 1'b0, nexp: 2};
        tbl[1] = '{u: 5'd16, nb: 6,  mul: 16, umul: 1, seed: 3,    fl: 1'b0, nexp: 3};
        tbl[2] = '{u: 5'd8,  nb: 5,  mul: 8,  umul: 1, seed: 'h40, fl: 1'b1, nexp: 2};
        tbl[3] = '{u: 5'd3,  nb: 40, mul: 3,  umul: 1, seed: 7,    fl: 1'b1, nexp: 0};
        tbl[4] = '{u: 5'd2,  nb: 16, mul: 2,  umul: 1, seed: 'h90, fl: 1'b0, nexp: 1};
        tbl[5] = '{u: 5'd16, nb: 3,  mul: 5,  umul: 2, seed: 'h11, fl: 1'b1, nexp: 2};

        rst = 1'b1; vs = 1'b0; de = 1'b0; full = 1'b0; units = 5'd4; din = '0;
        repeat (3) tick();
        chk("reset WR_O",   LW'(wr),   '0);
        chk("reset DATA_O", dout,      '0);
        chk("reset OVF_O",  LW'(ovf),  '0);
        rst = 1'b0;
        tick();

        for (int s = 0; s < 6; s++) begin
            obs_q.delete();
            exp_q.delete();
            nu = (tbl[s].u inside {5'd2, 5'd4, 5'd8, 5'd16}) ? int'(tbl[s].u) : 0;
            vs_pulse(tbl[s].u);
            tick();
            // Mid-frame change of the requested size must have no effect.
            units = (tbl[s].u == 5'd16) ? 5'd8 : 5'd16;
            for (int k = 0; k < tbl[s].nb; k++)
                beat(mk_beat(k, tbl[s].mul, tbl[s].umul, tbl[s].seed, (nu > 0) ? nu : 4), nu);
            repeat (3) tick();
            if (tbl[s].fl) vs_pulse(tbl[s].u);
            compare($sformatf("vec%0d", s), tbl[s].nexp);
            if (s == 0 && obs_q.size() > 0) begin
                for (int j = 0; j < N; j++) w0[j*B +: B] = 8'(j / 4);
                chk("vec0 word0 unit j = j/4", obs_q[0].w, w0);
            end
        end

        // Reset in the middle of a word discards it; next word holds only new data.
        obs_q.delete(); exp_q.delete();
        vs_pulse(5'd2);
        tick();
        for (int k = 0; k < 7; k++) beat(mk_beat(k, 1, 1, 'hE0, 2), 2);
        rst = 1'b1;
        mq.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) beat(mk_beat(k, 2, 1, 'h20, 2), 2);
        compare("midreset", 1);
        chk("OVF_O idle before overflow", LW'(ovf), '0);

        // Write while FIFO full: strobe still issued, overflow sticky through VS.
        obs_q.delete(); exp_q.delete();
        vs_pulse(5'd16);
        tick();
        full = 1'b1;
        for (int k = 0; k < 2; k++) beat(mk_beat(k, 9, 1, 1, 16), 16);
        compare("full", 1);
        full = 1'b0;
        chk("OVF_O set", LW'(ovf), LW'(1));
        vs_pulse(5'd16);
        tick();
        chk("OVF_O held through VS", LW'(ovf), LW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("OVF_O cleared by reset", LW'(ovf), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
